// File: rtl/adc_lvds_emulator_pkg.sv
// Shared encodings for the ADC serial-link transmit emulator.
package adc_lvds_emulator_pkg;

  // Word source selection, sampled at each word load
  typedef enum logic [1:0] {
    MODE_EXT   = 2'b00,
    MODE_RAMP  = 2'b01,
    MODE_FIXED = 2'b10,
    MODE_ZERO  = 2'b11
  } mode_e;

  // Link state: waiting for enable, or shifting a word out
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/adc_lvds_emulator.sv
// ADC serial-link transmitter: serializes WIDTH-bit words MSB first with a
// half-rate bit clock and a word-alignment frame marker.
module adc_lvds_emulator
  import adc_lvds_emulator_pkg::*;
#(
  parameter int unsigned      WIDTH     = 12,
  parameter int unsigned      FRAME_HI  = 6,
  parameter logic [WIDTH-1:0] PATTERN   = 12'hAAA,
  parameter logic [WIDTH-1:0] IDLE_WORD = 12'h800
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             adc_fast_clk,
  output logic             adc_frame,
  output logic             adc_data_p,
  output logic             adc_data_ready,
  output logic             underrun
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             fast_clk_q, fast_clk_d;
  logic             frame_q, frame_d;
  logic             data_p_q, data_p_d;
  logic [WIDTH-1:0] ramp_cnt_q, ramp_cnt_d;
  logic             data_ready_q, data_ready_d;
  logic             underrun_q, underrun_d;

  logic             boundary_c;
  logic             load_c;
  logic [WIDTH-1:0] word_c;
  logic             ramp_adv_c;
  logic             underrun_c;
  logic [CNT_W-1:0] nxt_cnt_c;
  mode_e            mode_c;

  // Word boundary and load decision; a load on the boundary keeps the link gapless
  always_comb begin
    mode_c     = mode_e'(mode);
    boundary_c = (state_q == ST_SHIFT) && fast_clk_q && (bit_cnt_q == LAST_BIT);
    load_c     = enable && ((state_q == ST_IDLE) || boundary_c);
    nxt_cnt_c  = bit_cnt_q + CNT_W'(1);
  end

  assign sample_ready = load_c && (mode_c == MODE_EXT);

  // Source selection for the word being loaded
  always_comb begin
    word_c     = '0;
    ramp_adv_c = 1'b0;
    underrun_c = 1'b0;
    case (mode_c)
      MODE_EXT: begin
        if (sample_valid) begin
          word_c = sample_in;
        end else begin
          word_c     = IDLE_WORD;
          underrun_c = 1'b1;
        end
      end
      MODE_RAMP: begin
        word_c     = ramp_cnt_q;
        ramp_adv_c = 1'b1;
      end
      MODE_FIXED: word_c = PATTERN;
      default:    word_c = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_c) state_d = ST_SHIFT;
      ST_SHIFT: if (boundary_c && !load_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; data/frame only move while fast_clk falls
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    fast_clk_d   = fast_clk_q;
    frame_d      = frame_q;
    data_p_d     = data_p_q;
    ramp_cnt_d   = ramp_cnt_q;
    data_ready_d = data_ready_q;
    underrun_d   = 1'b0;
    if (load_c) begin
      shreg_d    = word_c;
      bit_cnt_d  = '0;
      fast_clk_d = 1'b0;
      data_p_d   = word_c[WIDTH-1];
      frame_d    = (FRAME_HI > 0);
      underrun_d = underrun_c;
      if (ramp_adv_c) ramp_cnt_d = ramp_cnt_q + WIDTH'(1);
      if (boundary_c) data_ready_d = 1'b1;
    end else if (boundary_c) begin
      fast_clk_d   = 1'b0;
      frame_d      = 1'b0;
      data_p_d     = 1'b0;
      data_ready_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      fast_clk_d = ~fast_clk_q;
      if (fast_clk_q) begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = nxt_cnt_c;
        data_p_d  = shreg_d[WIDTH-1];
        frame_d   = (32'(nxt_cnt_c) < FRAME_HI);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      fast_clk_q   <= 1'b0;
      frame_q      <= 1'b0;
      data_p_q     <= 1'b0;
      ramp_cnt_q   <= '0;
      data_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      fast_clk_q   <= fast_clk_d;
      frame_q      <= frame_d;
      data_p_q     <= data_p_d;
      ramp_cnt_q   <= ramp_cnt_d;
      data_ready_q <= data_ready_d;
      underrun_q   <= underrun_d;
    end
  end

  assign adc_fast_clk   = fast_clk_q;
  assign adc_frame      = frame_q;
  assign adc_data_p     = data_p_q;
  assign adc_data_ready = data_ready_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_adc_lvds_emulator.sv
// Bench for adc_lvds_emulator: serial words are recovered at fast_clk rises and
// compared against a queue of words predicted from the source-selection rules.
module tb_adc_lvds_emulator;

  localparam int W  = 12;
  localparam int FH = 6;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    mode;
  logic [W-1:0]  sample_in;
  logic          sample_valid;
  logic          sample_ready, adc_fast_clk, adc_frame, adc_data_p, adc_data_ready, underrun;

  logic          s_enable;
  logic [SW-1:0] s_sample_in;
  logic          s_ready, s_fclk, s_frame, s_data, s_dready, s_underrun;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int m_ramp = 0;

  always #5 clk = ~clk;

  adc_lvds_emulator dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .adc_fast_clk(adc_fast_clk), .adc_frame(adc_frame), .adc_data_p(adc_data_p),
    .adc_data_ready(adc_data_ready), .underrun(underrun)
  );

  // Narrow instance: ramp wrap and frame held high when FRAME_HI >= WIDTH
  adc_lvds_emulator #(.WIDTH(SW), .FRAME_HI(6), .PATTERN(4'hA), .IDLE_WORD(4'h8)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(s_enable), .mode(2'b01),
    .sample_in(s_sample_in), .sample_valid(1'b0), .sample_ready(s_ready),
    .adc_fast_clk(s_fclk), .adc_frame(s_frame), .adc_data_p(s_data),
    .adc_data_ready(s_dready), .underrun(s_underrun)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endfunction

  // Main monitor: deserialize at fast_clk rises, word starts at frame rising
  initial begin
    logic prev_fc, prev_fr, in_word;
    int idx;
    logic [W-1:0] sh;
    prev_fc = 1'b0; prev_fr = 1'b0; in_word = 1'b0; idx = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_fc = 1'b0; prev_fr = 1'b0; in_word = 1'b0; idx = 0;
      end else begin
        if (adc_fast_clk && !prev_fc) begin
          if (adc_frame && !prev_fr && !in_word) begin
            in_word = 1'b1; idx = 0; sh = '0;
          end
          if (in_word) begin
            chk1("frame_slot", adc_frame, idx < FH);
            sh = {sh[W-2:0], adc_data_p};
            idx++;
            if (idx == W) begin
              in_word = 1'b0;
              if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_word: got 0x%0h expected none at %0t", sh, $time);
              end else begin
                chk("word", 32'(sh), 32'(exp_q.pop_front()));
              end
            end
          end
          prev_fr = adc_frame;
        end
        prev_fc = adc_fast_clk;
      end
    end
  end

  // Narrow-instance monitor: continuous ramp, 4 bits per word
  int s_words = 0;
  initial begin
    logic prev_fc;
    int idx, s_exp;
    logic [SW-1:0] sh;
    prev_fc = 1'b0; idx = 0; s_exp = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_fc = 1'b0; idx = 0; s_exp = 0;
      end else begin
        if (s_fclk && !prev_fc) begin
          chk1("s_frame", s_frame, 1'b1);
          sh = {sh[SW-2:0], s_data};
          idx++;
          if (idx == SW) begin
            chk("s_word", 32'(sh), 32'(s_exp));
            s_exp = (s_exp + 1) % (1 << SW);
            s_words++;
            idx = 0;
          end
        end
        prev_fc = s_fclk;
      end
    end
  end

  function automatic logic [W-1:0] model_word(input logic [1:0] md, input logic vld,
                                               input logic [W-1:0] smp);
    case (md)
      2'd0:    return vld ? smp : 12'h800;
      2'd1: begin
        model_word = W'(m_ramp);
        m_ramp = (m_ramp + 1) % (1 << W);
      end
      2'd2:    return 12'hAAA;
      default: return '0;
    endcase
  endfunction

  // Send n back-to-back words from idle; enable drops at bit drop_bit of the last word
  task automatic run(input int n, input int md_sel, input int vld_sel, input int smp_sel,
                     input int drop_bit);
    logic [1:0] md;
    logic vld;
    logic [W-1:0] smp, ew;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      md  = (md_sel < 0)  ? 2'($urandom_range(0, 3)) : 2'(md_sel);
      vld = (vld_sel < 0) ? 1'($urandom_range(0, 1)) : 1'(vld_sel);
      smp = (smp_sel < 0) ? W'($urandom) : W'(smp_sel);
      mode = md; sample_valid = vld; sample_in = smp; enable = 1'b1;
      ew = model_word(md, vld, smp);
      exp_q.push_back(ew);
      #1 chk1("sample_ready_load", sample_ready, md == 2'd0);
      @(posedge clk); #1;
      chk1("underrun", underrun, (md == 2'd0) && !vld);
      chk1("load_fast_clk", adc_fast_clk, 1'b0);
      chk1("load_msb", adc_data_p, ew[W-1]);
      chk1("load_frame", adc_frame, 1'b1);
      chk1("data_ready", adc_data_ready, k > 0);
      sample_valid = 1'($urandom_range(0, 1));
      for (int c = 1; c < 2 * W; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin
          chk1("first_rise", adc_fast_clk, 1'b1);
          chk1("underrun_pulse_end", underrun, 1'b0);
        end
        if (c == 7) chk1("ready_mid_word", sample_ready, 1'b0);
        if (k == n - 1 && c == 2 * drop_bit + 1) enable = 1'b0;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk1("idle_fast_clk", adc_fast_clk, 1'b0);
    chk1("idle_frame", adc_frame, 1'b0);
    chk1("idle_data", adc_data_p, 1'b0);
    chk1("idle_data_ready", adc_data_ready, 1'b0);
    chk1("idle_ready", sample_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; sample_in = '0; sample_valid = 1'b0;
    s_enable = 1'b1; s_sample_in = '0;
    repeat (3) @(negedge clk);
    chk1("rst_fast_clk", adc_fast_clk, 1'b0);
    chk1("rst_frame", adc_frame, 1'b0);
    chk1("rst_data", adc_data_p, 1'b0);
    chk1("rst_data_ready", adc_data_ready, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk1("rst_ready", sample_ready, 1'b0);
    reset_n = 1'b1;

    run(3, 1, 0, 0, 11);        // ramp 0,1,2
    run(1, 0, 1, 12'hABC, 11);  // external sample
    run(1, 0, 0, 0, 11);        // underrun -> mid-scale
    run(2, 2, 0, 0, 11);        // fixed pattern
    run(1, 3, 0, 0, 11);        // zero
    run(3, 1, 0, 0, 5);         // enable dropped at bit 5 of last word

    // Reset mid-word at bit 7
    @(negedge clk);
    mode = 2'd1; enable = 1'b1;
    exp_q.push_back(model_word(2'd1, 1'b0, '0));
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1 reset_n = 1'b0; enable = 1'b0;
    #1;
    chk1("mid_rst_fast_clk", adc_fast_clk, 1'b0);
    chk1("mid_rst_frame", adc_frame, 1'b0);
    chk1("mid_rst_data", adc_data_p, 1'b0);
    chk1("mid_rst_data_ready", adc_data_ready, 1'b0);
    chk1("mid_rst_ready", sample_ready, 1'b0);
    void'(exp_q.pop_back());
    m_ramp = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk1("post_rst_idle", adc_fast_clk | adc_frame | adc_data_p, 1'b0);
    end

    run(2, 1, 0, 0, 11);        // ramp restarts at 0
    run(20, -1, -1, -1, int'($urandom_range(1, 11)));

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk1("s_ramp_wrapped", s_words > (1 << SW), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
